// File: rtl/neuron_seq_ctrl.sv
// rtl/neuron_seq_ctrl.sv - per-layer MAC sequencer: clear, stream, drain, activate, write per neuron
// Optional stall input enabled by defining NEURON_SEQ_STALL_EN.
module neuron_seq_ctrl #(
    parameter int N_INPUTS  = 8,
    parameter int IDX_W     = 3,
    parameter int N_NEURONS = 2,
    parameter int NEU_W     = 1,
    parameter int MUL_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef NEURON_SEQ_STALL_EN
    input  logic             stall,
`endif
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] in_idx,
    output logic [NEU_W-1:0] neu_idx,
    output logic             ld_en,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             act_en,
    output logic             out_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_ACT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(N_INPUTS - 1);
    localparam logic [NEU_W-1:0] LAST_NEU = NEU_W'(N_NEURONS - 1);
    localparam logic [1:0]       LAST_DR  = 2'(MUL_LAT);

    state_t             state;
    logic [MUL_LAT:0]   vp;
    logic [1:0]         dcnt;
    logic               hold;

`ifdef NEURON_SEQ_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // A stall freezes every register, so the whole schedule simply shifts later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            vp      <= '0;
            in_idx  <= '0;
            neu_idx <= '0;
            dcnt    <= '0;
        end else if (!hold) begin
            vp[0] <= (state == S_STREAM);
            for (int i = 1; i <= MUL_LAT; i++) begin
                vp[i] <= vp[i-1];
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CLR;
                        neu_idx <= '0;
                        in_idx  <= '0;
                    end
                end
                S_CLR: begin
                    in_idx <= '0;
                    state  <= S_STREAM;
                end
                S_STREAM: begin
                    if (in_idx == LAST_IN) begin
                        state <= S_DRAIN;
                        dcnt  <= '0;
                    end else begin
                        in_idx <= in_idx + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Last product reaches the accumulator in the final drain cycle.
                    if (dcnt == LAST_DR) begin
                        state <= S_ACT;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                S_ACT: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (neu_idx == LAST_NEU) begin
                        state <= S_DONE;
                    end else begin
                        neu_idx <= neu_idx + NEU_W'(1);
                        in_idx  <= '0;
                        state   <= S_CLR;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign ld_en   = (state == S_STREAM) && !hold;
    assign acc_clr = (state == S_CLR)    && !hold;
    assign act_en  = (state == S_ACT)    && !hold;
    assign out_en  = (state == S_WRITE)  && !hold;
    assign done    = (state == S_DONE)   && !hold;
    assign acc_en  = vp[MUL_LAT]         && !hold;

endmodule
